// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad emulator and anything else that talks
// to the 4x4 matrix: controller states, keycode names and the idle levels
// of the active-low row/column lines.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Both matrix directions are active-low, so all-ones means nothing driven.
  localparam logic [3:0] ROWS_IDLE = 4'b1111;
  localparam logic [3:0] COLS_IDLE = 4'b1111;

endpackage

// File: rtl/keypad_key_map.sv
// keypad_key_map
// Purely combinational translation of a keycode into the matrix position
// of that key, as active-high one-hots (bit 0 = row 0 / column 0).
// Ports:
//   keycode_i     4-bit keycode, same encoding as the scanner output
//   row_onehot_o  one-hot row of the key
//   col_onehot_o  one-hot column of the key
module keypad_key_map
  import keypad_pkg::*;
(
  input  logic [3:0] keycode_i,
  output logic [3:0] row_onehot_o,
  output logic [3:0] col_onehot_o
);

  always_comb begin
    row_onehot_o = 4'b0000;
    col_onehot_o = 4'b0000;
    case (keycode_i)
      KEY_1:    begin row_onehot_o = 4'b0001; col_onehot_o = 4'b0001; end
      KEY_2:    begin row_onehot_o = 4'b0001; col_onehot_o = 4'b0010; end
      KEY_3:    begin row_onehot_o = 4'b0001; col_onehot_o = 4'b0100; end
      KEY_A:    begin row_onehot_o = 4'b0001; col_onehot_o = 4'b1000; end
      KEY_4:    begin row_onehot_o = 4'b0010; col_onehot_o = 4'b0001; end
      KEY_5:    begin row_onehot_o = 4'b0010; col_onehot_o = 4'b0010; end
      KEY_6:    begin row_onehot_o = 4'b0010; col_onehot_o = 4'b0100; end
      KEY_B:    begin row_onehot_o = 4'b0010; col_onehot_o = 4'b1000; end
      KEY_7:    begin row_onehot_o = 4'b0100; col_onehot_o = 4'b0001; end
      KEY_8:    begin row_onehot_o = 4'b0100; col_onehot_o = 4'b0010; end
      KEY_9:    begin row_onehot_o = 4'b0100; col_onehot_o = 4'b0100; end
      KEY_C:    begin row_onehot_o = 4'b0100; col_onehot_o = 4'b1000; end
      KEY_STAR: begin row_onehot_o = 4'b1000; col_onehot_o = 4'b0001; end
      KEY_0:    begin row_onehot_o = 4'b1000; col_onehot_o = 4'b0010; end
      KEY_HASH: begin row_onehot_o = 4'b1000; col_onehot_o = 4'b0100; end
      KEY_D:    begin row_onehot_o = 4'b1000; col_onehot_o = 4'b1000; end
      default:  begin row_onehot_o = 4'b0000; col_onehot_o = 4'b0000; end
    endcase
  end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator
// Sits on the far side of a 4x4 keypad matrix and fakes a key press: while
// the scanner strobes the row of the requested key, the matching column is
// pulled low. The key is shown for HOLD_SCANS completed strobes of its row,
// then left released for RELEASE_SCANS strobes before done. If the target
// row stops being strobed for TIMEOUT_CYCLES cycles the request is aborted.
//
// state   | meaning
// IDLE    | waiting for req; cols released
// PRESS   | key shown on cols whenever its row is strobed
// RELEASE | key released, counting strobes before reporting done
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   req          start request, only looked at in IDLE
//   keycode_in   key to press
//   rows         active-low row strobes from the scanner
//   cols         active-low column lines back to the scanner (combinational)
//   busy         request in progress
//   done         one-cycle pulse when a request ends
//   err          with done: 1 = aborted by timeout
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_SCANS     = 4,
  parameter int unsigned RELEASE_SCANS  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [3:0] keycode_in,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_SCANS);
  localparam logic [7:0]  REL_LAST  = 8'(RELEASE_SCANS);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  logic [3:0]  map_row;
  logic [3:0]  map_col;

  state_e      state_q;
  logic [3:0]  row_q;
  logic [3:0]  col_q;
  logic [7:0]  scan_cnt_q;
  logic [7:0]  scan_cnt_d;
  logic [7:0]  scan_goal;
  logic [15:0] tmo_cnt_q;
  logic [15:0] tmo_cnt_d;
  logic        row_hit;
  logic        row_hit_q;
  logic        strobe_end;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  keypad_key_map u_key_map (
    .keycode_i    (keycode_in),
    .row_onehot_o (map_row),
    .col_onehot_o (map_col)
  );

  // Exact match only: no rows low or several rows low is never our row.
  // Gated in IDLE so a stale latched key cannot leave a pending strobe end
  // behind that would be counted as soon as a new request starts.
  assign row_hit    = (state_q != IDLE) && (~rows == row_q);
  assign strobe_end = row_hit_q & ~row_hit;

  assign scan_cnt_d = scan_cnt_q + 8'd1;
  assign tmo_cnt_d  = tmo_cnt_q + 16'd1;
  assign scan_goal  = (state_q == PRESS) ? HOLD_LAST : REL_LAST;

  // The scanner samples cols in the very cycle it drives the row, so this
  // path must stay combinational from rows.
  assign cols = (state_q == PRESS && row_hit) ? ~col_q : COLS_IDLE;

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= 4'b0000;
      col_q      <= 4'b0000;
      scan_cnt_q <= 8'd0;
      tmo_cnt_q  <= 16'd0;
      row_hit_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      row_hit_q <= row_hit;
      case (state_q)
        IDLE: begin
          if (req) begin
            row_q      <= map_row;
            col_q      <= map_col;
            scan_cnt_q <= 8'd0;
            tmo_cnt_q  <= 16'd0;
            busy_q     <= 1'b1;
            state_q    <= PRESS;
          end
        end
        PRESS, RELEASE: begin
          if (strobe_end) begin
            tmo_cnt_q <= 16'd0;
            if (scan_cnt_d == scan_goal) begin
              scan_cnt_q <= 8'd0;
              if (state_q == PRESS) begin
                state_q <= RELEASE;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              scan_cnt_q <= scan_cnt_d;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Scanner went quiet on our row: give up and report it.
            state_q    <= IDLE;
            scan_cnt_q <= 8'd0;
            tmo_cnt_q  <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int HOLD = 4;
  localparam int REL  = 4;
  localparam int TMO  = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [3:0] keycode_in;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       busy;
  logic       done;
  logic       err;

  keypad_emulator #(
    .HOLD_SCANS     (HOLD),
    .RELEASE_SCANS  (REL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .keycode_in (keycode_in),
    .rows       (rows),
    .cols       (cols),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keypad face, row-major, left to right: position i is row i/4, col i%4.
  int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int m_phase;     // 0 = no request, 1 = key held, 2 = key let go
  int m_row;
  int m_col;
  int m_scans;     // target-row strobes finished in the current phase
  int m_quiet;     // cycles since the last finished target-row strobe
  bit m_was_hit;
  bit m_done;
  bit m_err;

  function automatic int key_pos(input logic [3:0] kc);
    for (int i = 0; i < 16; i++)
      if (layout[i] == int'(kc)) return i;
    return 0;
  endfunction

  function automatic bit m_strobed(input logic [3:0] r);
    logic [3:0] row_n;
    row_n = ~(4'b0001 << m_row);
    return (m_phase != 0) && (r == row_n);
  endfunction

  function automatic logic [3:0] m_cols(input logic [3:0] r);
    logic [3:0] col_n;
    col_n = ~(4'b0001 << m_col);
    return (m_phase == 1 && m_strobed(r)) ? col_n : 4'b1111;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_row = 3; m_col = 1; m_scans = 0; m_quiet = 0;
    m_was_hit = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rq, input logic [3:0] kc);
    bit hit;
    bit ended;
    int p;
    hit = m_strobed(r);
    ended = m_was_hit && !hit;
    m_was_hit = hit;
    m_done = 0;
    m_err = 0;
    if (m_phase == 0) begin
      if (rq) begin
        p = key_pos(kc);
        m_row = p / 4; m_col = p % 4;
        m_phase = 1; m_scans = 0; m_quiet = 0;
      end
    end else if (ended) begin
      m_scans++;
      m_quiet = 0;
      if (m_phase == 1 && m_scans == HOLD) begin
        m_phase = 2; m_scans = 0;
      end else if (m_phase == 2 && m_scans == REL) begin
        m_phase = 0; m_scans = 0; m_done = 1;
      end
    end else if (m_quiet + 1 == TMO) begin
      m_phase = 0; m_scans = 0; m_quiet = 0; m_done = 1; m_err = 1;
    end else begin
      m_quiet++;
    end
  endtask

  // ---------------- clocking helper ----------------
  bit         scan_en = 0;
  int         scan_idx = 0;
  logic [3:0] s_cols, s_rows;
  logic       s_busy, s_done, s_err;

  // Sample and compare at the falling edge, advance the model on the rising
  // edge, then move inputs (scanner included) 1 unit after it.
  task automatic tick();
    @(negedge clk);
    s_cols = cols; s_rows = rows; s_busy = busy; s_done = done; s_err = err;
    chk4("model_cols", cols, m_cols(rows));
    chk1("model_busy", busy, m_phase != 0);
    chk1("model_done", done, m_done);
    chk1("model_err", err, m_err);
    @(posedge clk);
    if (rst_n) model_step(rows, req, keycode_in);
    else model_reset();
    #1;
    if (scan_en) begin
      scan_idx = (scan_idx + 1) % 4;
      rows = ~(4'b0001 << scan_idx);
    end
  endtask

  task automatic start_req(input logic [3:0] kc);
    keycode_in = kc;
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  // Full hold/release cycle with the scanner running.
  task automatic full_press(input logic [3:0] kc, input logic [3:0] row_n, input logic [3:0] col_n);
    int pressed = 0, released = 0, stray = 0, cyc = 0, extra_done = 0;
    bit got_done = 0;
    logic got_err = 1'b1;
    logic busy_at_done = 1'b1;
    scan_en = 1;
    start_req(kc);
    while (!got_done && cyc < 300) begin
      tick();
      cyc++;
      if (s_cols != 4'b1111) begin
        if (s_rows == row_n && s_cols == col_n) pressed++;
        else stray++;
      end else if (s_busy && s_rows == row_n) begin
        released++;
      end
      if (s_done) begin
        got_done = 1; got_err = s_err; busy_at_done = s_busy;
      end
    end
    chk1("full_done_seen", got_done, 1'b1);
    chk1("full_err", got_err, 1'b0);
    chk1("full_busy_at_done", busy_at_done, 1'b0);
    chki("full_pressed_strobes", pressed, HOLD);
    chki("full_released_strobes", released, REL);
    chki("full_stray_cols", stray, 0);
    repeat (10) begin
      tick();
      if (s_done) extra_done++;
    end
    chki("full_no_extra_done", extra_done, 0);
    scan_en = 0;
    rows = ROWS_IDLE;
  endtask

  // Request a key then hold rows in a pattern that never finishes a strobe.
  task automatic timeout_run(input string name, input logic [3:0] kc, input logic [3:0] pat_a,
                             input logic [3:0] pat_b);
    int n = 0, bad_cols = 0;
    bit got_done = 0;
    scan_en = 0;
    rows = ROWS_IDLE;
    start_req(kc);
    while (n < 200) begin
      rows = (n % 2 == 0) ? pat_a : pat_b;
      tick();
      if (s_cols != 4'b1111) bad_cols++;
      if (s_done) begin
        got_done = 1;
        break;
      end
      n++;
    end
    chk1({name, "_done"}, got_done, 1'b1);
    chki({name, "_latency"}, n, TMO);
    chk1({name, "_err"}, s_err, 1'b1);
    chk1({name, "_busy"}, s_busy, 1'b0);
    chki({name, "_cols_quiet"}, bad_cols, 0);
    rows = ROWS_IDLE;
  endtask

  typedef struct {
    logic [3:0] key;
    logic [3:0] row_n;
    logic [3:0] col_n;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_left;
    int done_cnt;
    int wrong_key;
    bit found;

    vecs[0]  = '{4'd1,  4'b1110, 4'b1110};
    vecs[1]  = '{4'd2,  4'b1110, 4'b1101};
    vecs[2]  = '{4'd3,  4'b1110, 4'b1011};
    vecs[3]  = '{4'd10, 4'b1110, 4'b0111};
    vecs[4]  = '{4'd4,  4'b1101, 4'b1110};
    vecs[5]  = '{4'd5,  4'b1101, 4'b1101};
    vecs[6]  = '{4'd6,  4'b1101, 4'b1011};
    vecs[7]  = '{4'd11, 4'b1101, 4'b0111};
    vecs[8]  = '{4'd7,  4'b1011, 4'b1110};
    vecs[9]  = '{4'd8,  4'b1011, 4'b1101};
    vecs[10] = '{4'd9,  4'b1011, 4'b1011};
    vecs[11] = '{4'd12, 4'b1011, 4'b0111};
    vecs[12] = '{4'd14, 4'b0111, 4'b1110};
    vecs[13] = '{4'd0,  4'b0111, 4'b1101};
    vecs[14] = '{4'd15, 4'b0111, 4'b1011};
    vecs[15] = '{4'd13, 4'b0111, 4'b0111};

    rst_n = 1'b0;
    req = 1'b0;
    keycode_in = 4'd0;
    rows = ROWS_IDLE;
    model_reset();
    #3;
    chk4("reset_cols", cols, 4'b1111);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_err", err, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Key 5 with a rotating scanner.
    full_press(4'd5, 4'b1101, 4'b1101);

    // Every code against its matrix position, one strobe per row.
    foreach (vecs[v]) begin
      rows = ROWS_IDLE;
      start_req(vecs[v].key);
      for (int r = 0; r < 4; r++) begin
        rows = ~(4'b0001 << r);
        tick();
        chk4($sformatf("map_key%0d_row%0d", vecs[v].key, r), s_cols,
             (s_rows == vecs[v].row_n) ? vecs[v].col_n : 4'b1111);
      end
      rows = ROWS_IDLE;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
        tick();
        if (s_done) found = 1;
      end
      chk1($sformatf("map_key%0d_done", vecs[v].key), found, 1'b1);
      chk1($sformatf("map_key%0d_err", vecs[v].key), s_err, 1'b1);
    end

    // No strobes at all, then two rows low at once: both time out untouched.
    timeout_run("tmo_idle_rows", 4'd5, 4'b1111, 4'b1111);
    timeout_run("tmo_two_rows", 4'd1, 4'b1100, 4'b1100);
    timeout_run("tmo_two_rows_toggle", 4'd1, 4'b1100, 4'b1111);

    // Second request while busy must be dropped.
    scan_en = 1;
    start_req(4'd2);
    done_cnt = 0;
    wrong_key = 0;
    for (int c = 0; c < 120; c++) begin
      if (c >= 3 && c < 7) begin
        keycode_in = 4'd9;
        req = 1'b1;
      end else begin
        req = 1'b0;
      end
      tick();
      if (s_done) done_cnt++;
      if (s_cols != 4'b1111 && !(s_cols == 4'b1101 && s_rows == 4'b1110)) wrong_key++;
    end
    chki("busy_req_done_pulses", done_cnt, 1);
    chki("busy_req_wrong_key", wrong_key, 0);

    // Reset in the middle of a visible press.
    start_req(4'd5);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (cols == 4'b1101) found = 1;
    end
    chk1("rst_press_reached", found, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk4("rst_cols_now", cols, 4'b1111);
    chk1("rst_busy_now", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (s_done) done_cnt++;
    end
    chki("rst_no_done", done_cnt, 0);
    full_press(4'd5, 4'b1101, 4'b1101);

    // Random rows/requests checked cycle by cycle against the model.
    scan_en = 0;
    hold_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold_left == 0) begin
        case ($urandom_range(0, 9))
          0:       rows = ROWS_IDLE;
          1:       rows = 4'($urandom);
          default: rows = ~(4'b0001 << $urandom_range(0, 3));
        endcase
        hold_left = $urandom_range(1, 3);
      end
      hold_left--;
      req = ($urandom_range(0, 7) == 0);
      keycode_in = 4'($urandom);
      tick();
    end
    req = 1'b0;
    rows = ROWS_IDLE;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
